// File: rtl/ram2p_wf_ro_if.sv
// Bus bundle for the dual-port FIFO RAM: port-1 read/write, port-2 read-only.
interface ram2p_wf_ro_if #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 9
);
  logic                  EN;
  logic [ADDR_WIDTH-1:0] ADDR1;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] ADDR2;
  logic [DATA_WIDTH-1:0] DI;
  logic [DATA_WIDTH-1:0] DO1;
  logic [DATA_WIDTH-1:0] DO2;

  modport master (output EN, ADDR1, WE, ADDR2, DI, input DO1, DO2);
  modport slave  (input EN, ADDR1, WE, ADDR2, DI, output DO1, DO2);
endinterface

// File: rtl/ram2p_wf_ro.sv
// Simple dual-port RAM: port 1 write-first read/write, port 2 read-only with
// read-first behaviour on same-address collision. Registered outputs, 1-cycle latency.
module ram2p_wf_ro #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 9
) (
  input  logic           CLK,
  input  logic           RESET,
  ram2p_wf_ro_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] do1_q, do1_d;
  logic [DATA_WIDTH-1:0] do2_q, do2_d;
  logic                  wr;

  assign wr = !RESET && bus.EN && bus.WE;

  // Port 2 samples the array before this edge's write lands, giving old data on collision.
  always_comb begin
    do1_d = do1_q;
    do2_d = do2_q;
    if (RESET) begin
      do1_d = '0;
      do2_d = '0;
    end else if (bus.EN) begin
      do1_d = bus.WE ? bus.DI : mem_q[bus.ADDR1];
      do2_d = mem_q[bus.ADDR2];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem_q[bus.ADDR1] <= bus.DI;
  end

  always_ff @(posedge CLK) begin
    do1_q <= do1_d;
    do2_q <= do2_d;
  end

  assign bus.DO1 = do1_q;
  assign bus.DO2 = do2_q;
endmodule

// File: tb/tb_ram2p_wf_ro.sv
// Directed bench for ram2p_wf_ro: reset, write-first, collision, EN gating,
// boundary addresses and streaming with a lagging port-2 reader.
module tb_ram2p_wf_ro;
  localparam int DW = 17;
  localparam int AW = 9;

  logic CLK = 1'b0;
  logic RESET;
  int   n_assert = 0;
  int   n_fail   = 0;

  ram2p_wf_ro_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram2p_wf_ro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] prev;
    logic [DW-1:0] data;

    // Reset with a write attempt pending
    RESET = 1'b1; bus.EN = 1'b1; bus.WE = 1'b1; bus.DI = 17'h1ABCD;
    bus.ADDR1 = 9'd3; bus.ADDR2 = 9'd0;
    step(); step();
    check("rst_do1", bus.DO1, 17'h0);
    check("rst_do2", bus.DO2, 17'h0);
    RESET = 1'b0; bus.WE = 1'b0; bus.ADDR2 = 9'd3;
    step();
    check("rst_blocked_do2", bus.DO2, 17'h0);
    check("rst_blocked_do1", bus.DO1, 17'h0);

    // Write-first
    bus.WE = 1'b1; bus.ADDR1 = 9'd5; bus.DI = 17'h00123;
    step();
    check("wf_do1", bus.DO1, 17'h00123);
    bus.WE = 1'b0; bus.ADDR2 = 9'd5;
    step();
    check("wf_do2", bus.DO2, 17'h00123);
    check("wf_do1_rd", bus.DO1, 17'h00123);

    // Collision: port 2 sees old data, port 1 sees new
    bus.WE = 1'b1; bus.ADDR1 = 9'd7; bus.ADDR2 = 9'd0; bus.DI = 17'h0AAAA;
    step();
    bus.ADDR2 = 9'd7; bus.DI = 17'h05555;
    step();
    check("col_do1", bus.DO1, 17'h05555);
    check("col_do2_old", bus.DO2, 17'h0AAAA);
    bus.WE = 1'b0;
    step();
    check("col_do2_new", bus.DO2, 17'h05555);
    check("col_do1_rd", bus.DO1, 17'h05555);

    // EN low: no write, outputs hold
    bus.EN = 1'b0; bus.WE = 1'b1; bus.ADDR1 = 9'd9; bus.ADDR2 = 9'd9; bus.DI = 17'h1FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_hold_do1", bus.DO1, 17'h05555);
      check("en_hold_do2", bus.DO2, 17'h05555);
    end
    bus.EN = 1'b1; bus.WE = 1'b0;
    step();
    check("en_nowr_do1", bus.DO1, 17'h0);
    check("en_nowr_do2", bus.DO2, 17'h0);

    // Mid-operation reset keeps memory contents
    RESET = 1'b1; bus.WE = 1'b1; bus.ADDR1 = 9'd5; bus.DI = 17'h00001;
    step();
    check("mid_rst_do1", bus.DO1, 17'h0);
    check("mid_rst_do2", bus.DO2, 17'h0);
    RESET = 1'b0; bus.WE = 1'b0; bus.ADDR1 = 9'd5; bus.ADDR2 = 9'd7;
    step();
    check("post_rst_do1", bus.DO1, 17'h00123);
    check("post_rst_do2", bus.DO2, 17'h05555);

    // Boundary addresses
    bus.WE = 1'b1; bus.ADDR1 = 9'd0; bus.DI = 17'h11111;
    step();
    bus.ADDR1 = 9'd511; bus.DI = 17'h1EEEE;
    step();
    check("bnd_wr_top", bus.DO1, 17'h1EEEE);
    bus.WE = 1'b0; bus.ADDR2 = 9'd0; bus.ADDR1 = 9'd511;
    step();
    check("bnd_p2_lo", bus.DO2, 17'h11111);
    check("bnd_p1_hi", bus.DO1, 17'h1EEEE);
    bus.ADDR2 = 9'd511; bus.ADDR1 = 9'd0;
    step();
    check("bnd_p2_hi", bus.DO2, 17'h1EEEE);
    check("bnd_p1_lo", bus.DO1, 17'h11111);

    // Streaming writes 0..15 with port 2 reading one address behind
    prev = 17'h1EEEE;
    for (int i = 0; i < 16; i++) begin
      data = 17'h10000 | DW'(i * 17'h111);
      bus.WE = 1'b1; bus.ADDR1 = AW'(i); bus.ADDR2 = AW'(i - 1); bus.DI = data;
      step();
      check("str_do1", bus.DO1, data);
      check("str_do2", bus.DO2, prev);
      prev = data;
    end
    bus.WE = 1'b0; bus.ADDR2 = 9'd15; bus.ADDR1 = 9'd0;
    step();
    check("str_last_do2", bus.DO2, prev);
    check("str_first_do1", bus.DO1, 17'h10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
